// File: rtl/ps2_mouse_tracker_if.sv
// Signal bundle between the PS/2 line driver and the mouse tracker:
// serial lines in, cursor position, buttons and event pulses out.
interface ps2_mouse_tracker_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] mouse_x;
    logic [8:0] mouse_y;
    logic       btn_left;
    logic       btn_right;
    logic       packet_valid;
    logic       frame_error;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  mouse_x,
        input  mouse_y,
        input  btn_left,
        input  btn_right,
        input  packet_valid,
        input  frame_error
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output mouse_x,
        output mouse_y,
        output btn_left,
        output btn_right,
        output packet_valid,
        output frame_error
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: conditions the serial lines, deframes bytes, assembles
// 3-byte movement packets and integrates them into a clamped cursor position.
module ps2_mouse_tracker #(
    parameter int unsigned X_MAX      = 632,
    parameter int unsigned Y_MAX      = 469,
    parameter int unsigned X_INIT     = 320,
    parameter int unsigned Y_INIT     = 240,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    ps2_mouse_tracker_if.slave     bus
);

    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 9;
    localparam int unsigned SW  = 11;
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } frame_state_t;

    // line synchronizers
    logic           r_clk_s1, r_clk_s2;
    logic           r_dat_s1, r_dat_s2;

    // clock filter and sample strobe
    logic           r_clk_filt;
    logic [FCW-1:0] r_filt_cnt;
    logic           r_strobe;
    logic           r_bit;

    // frame receiver
    frame_state_t   r_state, w_state_nx;
    logic [7:0]     r_shift, w_shift_nx;
    logic [2:0]     r_bitcnt, w_bitcnt_nx;
    logic           r_par, w_par_nx;
    logic [TW-1:0]  r_timer, w_timer_nx;
    logic           w_byte_ok_c;
    logic           w_ferr_c;
    logic           w_timeout_c;

    // packet assembler
    logic [1:0]     r_idx;
    logic           r_p_left, r_p_right;
    logic           r_p_xs, r_p_ys;
    logic           r_p_xovf, r_p_yovf;
    logic [7:0]     r_dx, r_dy;
    logic           r_apply;

    // outputs
    logic [XW-1:0]  r_mouse_x;
    logic [YW-1:0]  r_mouse_y;
    logic           r_btn_left, r_btn_right;
    logic           r_packet_valid, r_frame_error;

    logic [SW-1:0]  w_x_sum, w_y_sum;
    logic [XW-1:0]  w_x_clamp_c;
    logic [YW-1:0]  w_y_clamp_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN samples disagree with it in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_strobe   <= 1'b0;
            r_bit      <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
                r_strobe   <= ~r_clk_s2;
                r_bit      <= r_dat_s2;
            end else begin
                r_filt_cnt <= r_filt_cnt + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_shift  <= w_shift_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_par    <= w_par_nx;
            r_timer  <= w_timer_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_bitcnt_nx = r_bitcnt;
        w_par_nx    = r_par;
        w_timer_nx  = '0;
        w_byte_ok_c = 1'b0;
        w_ferr_c    = 1'b0;
        w_timeout_c = (r_state != S_IDLE) && !r_strobe &&
                      (r_timer == TW'(TIMEOUT - 1));

        case (r_state)
            S_IDLE: begin
                if (r_strobe && !r_bit) begin
                    w_state_nx  = S_DATA;
                    w_bitcnt_nx = '0;
                end
            end
            S_DATA: begin
                if (r_strobe) begin
                    w_shift_nx = {r_bit, r_shift[7:1]};
                    if (r_bitcnt == 3'd7) begin
                        w_state_nx = S_PARITY;
                    end else begin
                        w_bitcnt_nx = r_bitcnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (r_strobe) begin
                    w_par_nx   = r_bit;
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (r_strobe) begin
                    w_state_nx = S_IDLE;
                    if (r_bit && (^{r_shift, r_par})) begin
                        w_byte_ok_c = 1'b1;
                    end else begin
                        w_ferr_c = 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // A stalled frame is abandoned after TIMEOUT idle cycles.
        if (r_state != S_IDLE && !r_strobe) begin
            w_timer_nx = r_timer + TW'(1);
        end
        if (w_timeout_c) begin
            w_state_nx = S_IDLE;
            w_ferr_c   = 1'b1;
            w_timer_nx = '0;
        end
    end

    // Cursor update: sign-extend the 9-bit deltas, PS/2 +dy is screen-up.
    always_comb begin
        w_x_sum = SW'({1'b0, r_mouse_x}) + {{2{r_p_xs}}, r_p_xs, r_dx};
        w_y_sum = SW'({2'b00, r_mouse_y}) - {{2{r_p_ys}}, r_p_ys, r_dy};

        if (w_x_sum[SW-1]) begin
            w_x_clamp_c = '0;
        end else if (w_x_sum[XW-1:0] > XW'(X_MAX)) begin
            w_x_clamp_c = XW'(X_MAX);
        end else begin
            w_x_clamp_c = w_x_sum[XW-1:0];
        end

        if (w_y_sum[SW-1]) begin
            w_y_clamp_c = '0;
        end else if (w_y_sum[XW-1:0] > XW'(Y_MAX)) begin
            w_y_clamp_c = YW'(Y_MAX);
        end else begin
            w_y_clamp_c = w_y_sum[YW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx          <= '0;
            r_p_left       <= 1'b0;
            r_p_right      <= 1'b0;
            r_p_xs         <= 1'b0;
            r_p_ys         <= 1'b0;
            r_p_xovf       <= 1'b0;
            r_p_yovf       <= 1'b0;
            r_dx           <= '0;
            r_dy           <= '0;
            r_apply        <= 1'b0;
            r_mouse_x      <= XW'(X_INIT);
            r_mouse_y      <= YW'(Y_INIT);
            r_btn_left     <= 1'b0;
            r_btn_right    <= 1'b0;
            r_packet_valid <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_packet_valid <= 1'b0;
            r_apply        <= 1'b0;
            r_frame_error  <= w_ferr_c;

            if (w_ferr_c) begin
                r_idx <= '0;
            end else if (w_byte_ok_c) begin
                case (r_idx)
                    2'd0: begin
                        // bit3 is always set in a header byte; anything else is a stray byte
                        if (r_shift[3]) begin
                            r_p_left  <= r_shift[0];
                            r_p_right <= r_shift[1];
                            r_p_xs    <= r_shift[4];
                            r_p_ys    <= r_shift[5];
                            r_p_xovf  <= r_shift[6];
                            r_p_yovf  <= r_shift[7];
                            r_idx     <= 2'd1;
                        end
                    end
                    2'd1: begin
                        r_dx  <= r_shift;
                        r_idx <= 2'd2;
                    end
                    2'd2: begin
                        r_dy    <= r_shift;
                        r_apply <= 1'b1;
                        r_idx   <= 2'd0;
                    end
                    default: r_idx <= 2'd0;
                endcase
            end

            if (r_apply) begin
                r_btn_left     <= r_p_left;
                r_btn_right    <= r_p_right;
                r_packet_valid <= 1'b1;
                if (!r_p_xovf) begin
                    r_mouse_x <= w_x_clamp_c;
                end
                if (!r_p_yovf) begin
                    r_mouse_y <= w_y_clamp_c;
                end
            end
        end
    end

    assign bus.mouse_x      = r_mouse_x;
    assign bus.mouse_y      = r_mouse_y;
    assign bus.btn_left     = r_btn_left;
    assign bus.btn_right    = r_btn_right;
    assign bus.packet_valid = r_packet_valid;
    assign bus.frame_error  = r_frame_error;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: directed PS/2 packets with
// hand-computed cursor results, popped by a monitor on each packet_valid.
module tb_ps2_mouse_tracker;

    localparam int unsigned TO = 3000;
    localparam int unsigned H  = 15;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       bl;
        logic       br;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    ps2_mouse_tracker_if bus();

    ps2_mouse_tracker #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    exp_t mon_e;
    int   total  = 0;
    int   bad    = 0;
    int   pv_cnt = 0;
    int   fe_cnt = 0;
    int   n_push = 0;
    int   fe_before;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops one expected entry per applied packet.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_error) fe_cnt++;
            if (bus.packet_valid) begin
                pv_cnt++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_packet: got x=%0d y=%0d expected none",
                             bus.mouse_x, bus.mouse_y);
                end else begin
                    mon_e = q.pop_front();
                    check("mouse_x",   int'(bus.mouse_x),   int'(mon_e.x));
                    check("mouse_y",   int'(bus.mouse_y),   int'(mon_e.y));
                    check("btn_left",  int'(bus.btn_left),  int'(mon_e.bl));
                    check("btn_right", int'(bus.btn_right), int'(mon_e.br));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        wait_cycles(H);
        bus.ps2_clk = 1'b0;
        wait_cycles(H);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        bus.ps2_data = 1'b1;
        wait_cycles(60);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int ex, input int ey, input logic ebl, input logic ebr);
        exp_t e;
        e.x  = 10'(ex);
        e.y  = 9'(ey);
        e.bl = ebl;
        e.br = ebr;
        q.push_back(e);
        n_push++;
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        wait_cycles(40);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(5);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mouse_x",   int'(bus.mouse_x),      320);
        check("rst_mouse_y",   int'(bus.mouse_y),      240);
        check("rst_btn_left",  int'(bus.btn_left),     0);
        check("rst_btn_right", int'(bus.btn_right),    0);
        check("rst_pv",        int'(bus.packet_valid), 0);
        check("rst_fe",        int'(bus.frame_error),  0);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset        = 1'b1;
        wait_cycles(3);
        do_reset();

        wait_cycles(10000);
        check("idle_mouse_x", int'(bus.mouse_x), 320);
        check("idle_mouse_y", int'(bus.mouse_y), 240);
        check("idle_pv_cnt",  pv_cnt, 0);
        check("idle_fe_cnt",  fe_cnt, 0);

        send_packet(8'h09, 8'h10, 8'h05, 336, 235, 1'b1, 1'b0);
        check("first_pv_cnt", pv_cnt, 1);

        do_reset();
        send_packet(8'h38, 8'hF0, 8'hF6, 304, 250, 1'b0, 1'b0);

        // walk x up to 630, then clamp at X_MAX
        send_packet(8'h08, 8'hFF, 8'h00, 559, 250, 1'b0, 1'b0);
        send_packet(8'h08, 8'h47, 8'h00, 630, 250, 1'b0, 1'b0);
        send_packet(8'h08, 8'h14, 8'h00, 632, 250, 1'b0, 1'b0);

        // y to 5, then clamp at 0
        send_packet(8'h08, 8'h00, 8'hF5, 632, 5, 1'b0, 1'b0);
        send_packet(8'h08, 8'h00, 8'h0A, 632, 0, 1'b0, 1'b0);

        // x down to 2, then clamp at 0
        send_packet(8'h18, 8'h00, 8'h00, 376, 0, 1'b0, 1'b0);
        send_packet(8'h18, 8'h01, 8'h00, 121, 0, 1'b0, 1'b0);
        send_packet(8'h18, 8'h89, 8'h00, 2,   0, 1'b0, 1'b0);
        send_packet(8'h18, 8'hF0, 8'h00, 0,   0, 1'b0, 1'b0);

        // parity error on byte 1 discards the partial packet
        fe_before = fe_cnt;
        send_byte(8'h08, 1'b0);
        send_byte(8'h33, 1'b1);
        check("parity_fe", fe_cnt, fe_before + 1);
        check("parity_x_hold", int'(bus.mouse_x), 0);
        send_packet(8'h08, 8'h01, 8'h00, 1, 0, 1'b0, 1'b0);

        // stray byte without sync bit is dropped silently
        fe_before = fe_cnt;
        send_byte(8'h00, 1'b0);
        send_packet(8'h29, 8'h02, 8'hFD, 3, 3, 1'b1, 1'b0);
        check("stray_no_fe", fe_cnt, fe_before);

        // overflow bits freeze their axis, buttons still update
        send_packet(8'h4A, 8'h50, 8'h00, 3, 3, 1'b0, 1'b1);
        send_packet(8'h8B, 8'h00, 8'h40, 3, 3, 1'b1, 1'b1);

        // stalled frame after 4 data bits
        fe_before = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus.ps2_data = 1'b1;
        wait_cycles(TO - 200);
        check("timeout_not_early", fe_cnt, fe_before);
        wait_cycles(400);
        check("timeout_fe", fe_cnt, fe_before + 1);
        send_packet(8'h08, 8'h01, 8'h00, 4, 3, 1'b0, 1'b0);

        wait_cycles(200);
        check("queue_drained", q.size(), 0);
        check("pv_total", pv_cnt, n_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
- Receives the PS/2 mouse serial stream (device-to-host) and assembles standard 3-byte movement packets.
- Integrates signed dx/dy into a clamped absolute cursor position and button state.
- Drives the mouse_x / mouse_y inputs of the VGA pixel painter, so the cursor position is held within the 640x480 visible area minus the 8x11 cursor sprite.

Parameters:
- X_MAX, 632, largest legal mouse_x (640 - 8 cursor width)
- Y_MAX, 469, largest legal mouse_y (480 - 11 cursor height)
- X_INIT, 320, mouse_x after reset
- Y_INIT, 240, mouse_y after reset
- FILTER_LEN, 8, consecutive equal clk samples required to accept a new ps2_clk level
- TIMEOUT, 50000, clk cycles with no ps2_clk falling edge before an in-progress frame is abandoned

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  PS/2 clock line, asynchronous
- ps2_data  in  1  PS/2 data line, asynchronous
- mouse_x  out  10  cursor column, 0..X_MAX
- mouse_y  out  9  cursor row, 0..Y_MAX
- btn_left  out  1  left button state from the last accepted packet
- btn_right  out  1  right button state from the last accepted packet
- packet_valid  out  1  one-cycle pulse when a packet is applied
- frame_error  out  1  one-cycle pulse when a byte is rejected

Behaviour:
- Single clock domain; reset is synchronous and active-high. All registers update on the clk rising edge.
- Reset values: mouse_x=X_INIT, mouse_y=Y_INIT, btn_left=0, btn_right=0, packet_valid=0, frame_error=0. Frame FSM goes to IDLE and the byte index goes to 0. A reset mid-frame or mid-packet discards all partial data.
- Input conditioning:
  - 2-FF synchronizer on ps2_clk and ps2_data.
  - Filtered ps2_clk changes level only after FILTER_LEN consecutive equal synchronized samples.
  - A falling edge of the filtered clock produces a 1-cycle sample strobe; ps2_data is captured on that strobe.
- Frame FSM (11-bit frame: start, 8 data LSB first, odd parity, stop):
  - IDLE: on strobe, if data=0 go to DATA with bit count 0; if data=1 stay in IDLE with no error.
  - DATA: shift in 8 bits, then go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: require stop=1 and odd parity over the 8 data bits plus the parity bit. On pass, emit the byte to the packet assembler; on fail, pulse frame_error. Return to IDLE either way.
  - Timeout: in DATA, PARITY or STOP, if TIMEOUT cycles pass without a strobe, return to IDLE, pulse frame_error and clear the byte index.
- Packet assembler:
  - Index 0: accept the byte only if bit3=1 (sync bit); otherwise drop it silently and keep index 0. This is how the block resynchronizes.
  - Index 1 gives dx, index 2 gives dy. The sign bits come from byte0[4] (x) and byte0[5] (y), forming 9-bit two's-complement values.
  - Any frame_error clears the index to 0, so the partial packet is discarded.
- Apply (cycle after byte 2's STOP check passes):
  - btn_left=byte0[0], btn_right=byte0[1].
  - If byte0[6] (x overflow) = 0: x_new = mouse_x + sext(dx), computed 11-bit signed. Clamp <0 to 0 and >X_MAX to X_MAX.
  - If byte0[7] (y overflow) = 0: y_new = mouse_y - sext(dy), 11-bit signed (PS/2 +dy is up; screen +y is down). Clamp to 0..Y_MAX.
  - If an overflow bit is set, that axis is unchanged; buttons still update.
  - packet_valid pulses high in the same cycle the new outputs are first visible.
  - Index returns to 0.
- Outputs are registered and hold their value between packets. There is no host-to-device transmission; the mouse is assumed already in stream mode.

Test Plan:
- Reset, then idle lines high for 10000 cycles -> mouse_x=320, mouse_y=240, buttons 0, no pulses.
- Packet 0x09,0x10,0x05 -> mouse_x=336, mouse_y=235, btn_left=1, exactly one packet_valid pulse.
- Packet 0x38,0xF0,0xF6 (both signs set, dx=-16, dy=-10) from 320/240 -> mouse_x=304, mouse_y=250.
- Clamping:
  - Starting at x=630, packet 0x08,0x14,0x00 -> mouse_x=632.
  - Starting at y=5, packet 0x08,0x00,0x0A -> mouse_y=0.
  - Starting at x=2, packet 0x18,0xF0,0x00 -> mouse_x=0.
- Parity error on byte 1 -> frame_error pulse, no position change. The following good packet 0x08,0x01,0x00 -> mouse_x increments by 1.
- Stray byte 0x00 before a packet (sync bit clear) -> dropped without frame_error; the next packet is applied correctly. Separately, stop ps2_clk after 4 data bits -> after TIMEOUT cycles frame_error pulses and the FSM returns to IDLE.
